dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port 4096x32 data memory between the pipelined CPU's MEM stage and
//   a debug/loader port. Arbitrates per cycle with CPU priority, an anti-starvation counter
//   and a debug lock mode for bursts. Stalls the CPU while it is denied.
//   Returns read data one cycle after the access and flags out-of-range addresses.
// PARAMETERS
//   AW        12   memory word-address width (depth = 2**AW)
//   DW        32   data width
//   MAX_WAIT  4    debug cycles denied before a forced debug grant (1..15)
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   reset, asynchronous, active-high
//   cpu_req      in   1   CPU MEM stage requests an access this cycle (lw/sw)
//   cpu_we       in   1   1 = write (sw), 0 = read (lw)
//   cpu_addr     in   DW  word address (rs + sign-extended imm)
//   cpu_wdata    in   DW  store data
//   cpu_stall    out  1   cpu_req & ~cpu_gnt; the pipeline freezes MEM and the stages upstream of it
//   cpu_rvalid   out  1   read data valid (1 cycle after the granted read)
//   cpu_rdata    out  DW  read data
//   dbg_req      in   1   debug access request; held until granted
//   dbg_we       in   1   1 = write
//   dbg_addr     in   DW  word address
//   dbg_wdata    in   DW  write data
//   dbg_lock     in   1   keep ownership after this access (burst)
//   dbg_gnt      out  1   debug access performed this cycle
//   dbg_rvalid   out  1   read data valid
//   dbg_rdata    out  DW  read data
//   mem_en       out  1   memory enable
//   mem_we       out  1   memory write enable
//   mem_addr     out  AW  memory word address
//   mem_wdata    out  DW  memory write data
//   mem_rdata    in   DW  memory read data, valid the cycle after mem_en & ~mem_we
//   oor_err      out  1   sticky: an access had addr[DW-1:AW] != 0
// BEHAVIOUR
//   Reset: state=ARB, wait_cnt=0, pending-read tag cleared, oor_err=0, all outputs 0.
//     A read in flight at reset produces no rvalid.
//   Grants are combinational within the cycle. At most one owner per cycle.
//     Owner drives mem_*. With no owner: mem_en=mem_we=0, mem_addr=mem_wdata=0.
//   State ARB:
//     - Only one requester: it wins.
//     - Both requesting: CPU wins, unless wait_cnt==MAX_WAIT; then debug wins and cpu_stall=1.
//     - Debug granted with dbg_lock=1: next state is DLOCK.
//   State DLOCK:
//     - Debug owns memory. CPU is never granted; cpu_stall=cpu_req.
//     - Cycle with dbg_req=0: no access; CPU still denied.
//     - Exit to ARB after a granted debug access with dbg_lock=0, or a cycle with dbg_req=0
//       and dbg_lock=0. ARB rules apply from the next cycle.
//   wait_cnt (4 bits):
//     - +1 each cycle with dbg_req & ~dbg_gnt, saturating at MAX_WAIT.
//     - Cleared on dbg_gnt or when dbg_req=0.
//   Read return: granted read registers owner tag. Next cycle the owner's rvalid=1 and
//     rdata=mem_rdata; otherwise rdata=0. Back-to-back reads give one rvalid per cycle.
//     A new access in the return cycle is allowed.
//   Out of range (addr[DW-1:AW]!=0):
//     - Access is granted but mem_en=0.
//     - Read returns rvalid with rdata=0; write is dropped.
//     - oor_err set next cycle, held until reset.
//   Width: mem_addr = addr[AW-1:0]; no byte lanes; full-word writes only.
// TESTING
//   1 CPU sw addr 5 data 0xDEADBEEF, then lw addr 5 -> mem_we pulse at 5;
//     cpu_rvalid next cycle with 0xDEADBEEF; cpu_stall=0 throughout.
//   2 CPU and debug request every cycle, MAX_WAIT=4 -> CPU granted 4 cycles, dbg_gnt on
//     cycle 5 with cpu_stall=1; pattern repeats every 5 cycles.
//   3 Debug lock burst: writes 0..7 with dbg_lock=1 until last, CPU requesting ->
//     8 consecutive dbg_gnt; cpu_stall=1 for 8 cycles; CPU granted cycle 9.
//   4 CPU lw addr 0x0000_1000 -> no mem_en; cpu_rvalid with 0; oor_err=1 until rst.
//   5 Debug read granted, rst pulsed before return cycle -> no dbg_rvalid; all outputs 0;
//     state ARB after release.
//   6 Regression with the CPU: 140-instruction lw/sw/beq program -> registers and all 4096
//     memory words match the golden model; a debug agent injecting reads to unused
//     addresses changes no result.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port data memory between the CPU MEM stage and a
//   debug/loader port. The CPU has priority each cycle, but a debug request
//   that has been denied MAX_WAIT cycles in a row is forced through. A debug
//   access with dbg_lock_i=1 keeps the memory for the debug port (burst mode)
//   until a cycle with dbg_lock_i=0. Read data returns one cycle after the
//   granted access, tagged to the port that issued it. Addresses with any bit
//   set above the memory range are granted but never reach the memory, and
//   they set a sticky error flag.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i CPU access request
//   cpu_stall_o                   CPU request denied this cycle
//   cpu_rvalid_o/rdata_o          CPU read return
//   dbg_req_i/we_i/addr_i/wdata_i debug access request (held until granted)
//   dbg_lock_i                    keep debug ownership after this access
//   dbg_gnt_o                     debug access performed this cycle
//   dbg_rvalid_o/rdata_o          debug read return
//   mem_en_o/we_o/addr_o/wdata_o  memory command
//   mem_rdata_i                   memory read data (one cycle latency)
//   oor_err_o                     sticky out-of-range access flag
module dmem_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [DW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_stall_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic          dbg_req_i,
  input  logic          dbg_we_i,
  input  logic [DW-1:0] dbg_addr_i,
  input  logic [DW-1:0] dbg_wdata_i,
  input  logic          dbg_lock_i,
  output logic          dbg_gnt_o,
  output logic          dbg_rvalid_o,
  output logic [DW-1:0] dbg_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          oor_err_o
);

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_DLOCK = 1'b1} state_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        rd_pend_q, rd_pend_d;   // a read was issued last cycle
  logic        rd_dbg_q, rd_dbg_d;     // ... by the debug port
  logic        rd_oor_q, rd_oor_d;     // ... to an out-of-range address
  logic        oor_err_q, oor_err_d;

  logic          cpu_gnt, dbg_gnt;
  logic          any_gnt;
  logic          sel_we;
  logic [DW-1:0] sel_addr, sel_wdata;
  logic          sel_oor;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ARB;
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_dbg_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
      oor_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_dbg_q   <= rd_dbg_d;
      rd_oor_q   <= rd_oor_d;
      oor_err_q  <= oor_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:   if (dbg_gnt && dbg_lock_i) state_d = ST_DLOCK;
      // In DLOCK the debug port is granted whenever it requests, so dropping
      // the lock exits both after a final access and on an idle cycle.
      ST_DLOCK: if (!dbg_lock_i) state_d = ST_ARB;
      default:  state_d = ST_ARB;
    endcase

    wait_cnt_d = wait_cnt_q;
    if (!dbg_req_i || dbg_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    rd_pend_d = any_gnt && !sel_we;
    rd_dbg_d  = dbg_gnt;
    rd_oor_d  = sel_oor;
    oor_err_d = oor_err_q || (any_gnt && sel_oor);
  end

  // Outputs: grants, memory command mux, read return
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (dbg_req_i && (!cpu_req_i || wait_cnt_q == MAX_WAIT_C)) begin
          dbg_gnt = 1'b1;
        end else if (cpu_req_i) begin
          cpu_gnt = 1'b1;
        end
      end
      ST_DLOCK: dbg_gnt = dbg_req_i;
      default: ;
    endcase
    any_gnt = cpu_gnt || dbg_gnt;

    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (dbg_gnt) begin
      sel_we    = dbg_we_i;
      sel_addr  = dbg_addr_i;
      sel_wdata = dbg_wdata_i;
    end else if (cpu_gnt) begin
      sel_we    = cpu_we_i;
      sel_addr  = cpu_addr_i;
      sel_wdata = cpu_wdata_i;
    end
    sel_oor = any_gnt && (sel_addr[DW-1:AW] != '0);

    // Out-of-range accesses are granted to the requester but never reach the memory.
    mem_en_o    = any_gnt && !sel_oor;
    mem_we_o    = any_gnt && sel_we && !sel_oor;
    mem_addr_o  = sel_addr[AW-1:0];
    mem_wdata_o = sel_wdata;

    cpu_stall_o = cpu_req_i && !cpu_gnt;
    dbg_gnt_o   = dbg_gnt;

    cpu_rvalid_o = rd_pend_q && !rd_dbg_q;
    dbg_rvalid_o = rd_pend_q && rd_dbg_q;
    cpu_rdata_o  = (cpu_rvalid_o && !rd_oor_q) ? mem_rdata_i : '0;
    dbg_rdata_o  = (dbg_rvalid_o && !rd_oor_q) ? mem_rdata_i : '0;
    oor_err_o    = oor_err_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 4096x32 memory.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_we, cpu_stall, cpu_rvalid;
  logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic          mem_en, mem_we, oor_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_stall_o(cpu_stall), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_lock_i(dbg_lock), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .oor_err_o(oor_err)
  );

  // Behavioural memory
  logic          ram_init;
  logic [DW-1:0] ram  [0:4095];
  logic [DW-1:0] gold [0:4095];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= '0;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
  endtask

  function automatic logic [31:0] ctl_vec();
    return {25'd0, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we, oor_err};
  endfunction

  function automatic logic [31:0] dat_or();
    return 32'(mem_addr) | mem_wdata | cpu_rdata | dbg_rdata;
  endfunction

  function automatic logic [31:0] t6_addr(input int i);
    return 32'(200 + i * 13);
  endfunction

  function automatic logic [31:0] t6_data(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0123_4567);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, op, cyc_n, bad_words;
    logic exp_hit, prev_cpu_rd, prev_dbg_rd, dbg_busy;
    logic [31:0] prev_cpu_exp;

    for (int i = 0; i < 4096; i++) gold[i] = '0;
    idle();
    rst = 1; ram_init = 1;
    @(negedge clk);
    @(negedge clk);
    ram_init = 0;
    #1;
    chk("reset ctl", ctl_vec(), 32'd0);
    chk("reset data", dat_or(), 32'd0);
    @(negedge clk); rst = 0;

    // T1: CPU store then load at word 5
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'd5; cpu_wdata = 32'hDEADBEEF; gold[5] = 32'hDEADBEEF;
    #1;
    chk("t1 sw en/we/stall", {29'd0, mem_en, mem_we, cpu_stall}, 32'b110);
    chk("t1 sw addr", 32'(mem_addr), 32'd5);
    @(negedge clk); cpu_we = 0;
    #1;
    chk("t1 lw en/we/stall", {29'd0, mem_en, mem_we, cpu_stall}, 32'b100);
    @(negedge clk); idle();
    #1;
    chk("t1 rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t1 rdata", cpu_rdata, 32'hDEADBEEF);

    // T2: both request every cycle -> debug forced through every 5th cycle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'(i);
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'd100;
      #1;
      exp_hit = (i % 5 == 4);
      chk($sformatf("t2 dbg_gnt c%0d", i), 32'(dbg_gnt), 32'(exp_hit));
      chk($sformatf("t2 stall c%0d", i), 32'(cpu_stall), 32'(exp_hit));
    end
    @(negedge clk); idle();

    // T3: locked debug burst of 8 writes while the CPU keeps requesting
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'd5;
      k = (c < 4) ? 0 : c - 4;
      if (k < 8) begin
        dbg_req = 1; dbg_we = 1; dbg_addr = 32'(k); dbg_wdata = 32'h100 + 32'(k);
        dbg_lock = (k < 7); gold[k] = 32'h100 + 32'(k);
      end else begin
        dbg_req = 0; dbg_lock = 0;
      end
      #1;
      exp_hit = (c >= 4 && c < 12);
      chk($sformatf("t3 dbg_gnt c%0d", c), 32'(dbg_gnt), 32'(exp_hit));
      chk($sformatf("t3 stall c%0d", c), 32'(cpu_stall), 32'(exp_hit));
      if (exp_hit) chk($sformatf("t3 addr c%0d", c), 32'(mem_addr), 32'(k));
    end
    @(negedge clk); idle();
    dbg_req = 1; dbg_addr = 32'd3;
    #1;
    chk("t3 readback gnt", 32'(dbg_gnt), 32'd1);
    @(negedge clk); idle();
    #1;
    chk("t3 readback rvalid", {30'd0, dbg_rvalid, cpu_rvalid}, 32'b10);
    chk("t3 readback rdata", dbg_rdata, 32'h103);

    // T4: out-of-range load and store
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_1000;
    #1;
    chk("t4 lw en/stall/oor", {29'd0, mem_en, cpu_stall, oor_err}, 32'd0);
    @(negedge clk);
    cpu_we = 1; cpu_addr = 32'h0000_1005; cpu_wdata = 32'h55;
    #1;
    chk("t4 rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t4 rdata", cpu_rdata, 32'd0);
    chk("t4 oor_err set", 32'(oor_err), 32'd1);
    chk("t4 sw mem_en", 32'(mem_en), 32'd0);
    @(negedge clk); idle();
    repeat (3) @(negedge clk);
    #1;
    chk("t4 oor_err held", 32'(oor_err), 32'd1);

    // T5: reset while a locked debug read is in flight
    @(negedge clk);
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'd5; dbg_lock = 1;
    #1;
    chk("t5 dbg_gnt", 32'(dbg_gnt), 32'd1);
    @(negedge clk); idle(); rst = 1;
    #1;
    chk("t5 reset ctl", ctl_vec(), 32'd0);
    chk("t5 reset data", dat_or(), 32'd0);
    @(negedge clk); rst = 0;
    cpu_req = 1; cpu_addr = 32'd5; dbg_req = 1; dbg_addr = 32'd6;
    #1;
    chk("t5 arb after rst", {30'd0, cpu_stall, dbg_gnt}, 32'd0);
    @(negedge clk); idle();

    // T6: CPU store/load program with a debug agent reading unused addresses
    op = 0; cyc_n = 0; prev_cpu_rd = 0; prev_dbg_rd = 0; dbg_busy = 0; prev_cpu_exp = '0;
    while (op < 48 && cyc_n < 2000) begin
      @(negedge clk);
      cyc_n++;
      if (prev_dbg_rd) dbg_busy = 0;
      if (!dbg_busy && (cyc_n % 3 == 0)) begin
        dbg_busy = 1; dbg_we = 0; dbg_lock = 0; dbg_addr = 32'(4000 + cyc_n % 90);
      end
      dbg_req = dbg_busy;
      cpu_req = 1;
      if (op < 24) begin
        cpu_we = 1; cpu_addr = t6_addr(op); cpu_wdata = t6_data(op);
      end else begin
        cpu_we = 0; cpu_addr = t6_addr(47 - op);
      end
      #1;
      if (prev_cpu_rd) begin
        chk($sformatf("t6 cpu rvalid op%0d", op), 32'(cpu_rvalid), 32'd1);
        chk($sformatf("t6 cpu rdata op%0d", op), cpu_rdata, prev_cpu_exp);
      end
      if (prev_dbg_rd) chk($sformatf("t6 dbg rdata cyc%0d", cyc_n), {31'd0, dbg_rvalid} | dbg_rdata, 32'd1);
      prev_cpu_rd = !cpu_stall && op >= 24;
      if (op >= 24) prev_cpu_exp = t6_data(47 - op);
      if (!cpu_stall) begin
        if (op < 24) gold[200 + op * 13] = t6_data(op);
        op++;
      end
      prev_dbg_rd = dbg_gnt;
    end
    chk("t6 ops completed", 32'(op), 32'd48);
    @(negedge clk); idle();
    #1;
    if (prev_cpu_rd) chk("t6 last rdata", cpu_rdata, prev_cpu_exp);
    @(negedge clk);

    bad_words = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== gold[i]) bad_words++;
    chk("final memory words wrong", 32'(bad_words), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
